onchip_ram_port_arbiter: RTL and testbench

- Shares one port of the 256x32 on-chip RAM (byte enables, address registered, q unregistered) between two Avalon-MM masters, m0 and m1.
- Round-robin arbitration; accepts at most one command per cycle.
- Tracks in-flight reads through a fixed-latency tag pipeline and steers readdatavalid back to the issuing master.
- Sits between the interconnect masters and the RAM port; a freeze input gates new grants for quiescing.

---
 rtl/onchip_ram_arb_pkg.sv | 14 +
 rtl/onchip_ram_port_arbiter_rd_tag_pipe.sv | 68 ++++++
 rtl/onchip_ram_port_arbiter.sv | 116 +++++++++++
 tb/tb_onchip_ram_port_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_ram_arb_pkg.sv
// Shared constants and the read-tag type for the on-chip RAM port arbiter.
package onchip_ram_arb_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int DATA_W_DEF  = 32;
    localparam int NUM_MASTERS = 2;

    // One in-flight read: valid marks a live slot, id names the issuing master.
    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

endpackage

// File: rtl/onchip_ram_port_arbiter_rd_tag_pipe.sv
// Fixed-latency tag pipeline that follows accepted reads to the RAM output.
// It steers ram_readdata to the issuing master. Each master keeps its last
// read word. An optional output register adds one cycle of latency.
module rd_tag_pipe
    import onchip_ram_arb_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RAM_RD_LAT = 1,
    parameter int REG_RDATA  = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push_valid,
    input  logic              push_id,
    input  logic [DATA_W-1:0] ram_readdata,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_data0,
    output logic [DATA_W-1:0] rsp_data1
);

    rd_tag_t [RAM_RD_LAT-1:0] tag_q, tag_d;
    rd_tag_t                  out_tag;
    logic [1:0]               hit;
    logic [1:0]               rvalid_q, rvalid_d;
    logic [DATA_W-1:0]        rdata0_q, rdata0_d;
    logic [DATA_W-1:0]        rdata1_q, rdata1_d;

    // Shift the tags one stage per cycle; a new accept enters at stage 0.
    always_comb begin
        tag_d          = tag_q;
        tag_d[0].valid = push_valid;
        tag_d[0].id    = push_id;
        for (int i = 1; i < RAM_RD_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Decode the tag that lines up with valid RAM data, and capture that word.
    always_comb begin
        out_tag  = tag_q[RAM_RD_LAT-1];
        hit[0]   = out_tag.valid & ~out_tag.id;
        hit[1]   = out_tag.valid &  out_tag.id;
        rvalid_d = hit;
        rdata0_d = hit[0] ? ram_readdata : rdata0_q;
        rdata1_d = hit[1] ? ram_readdata : rdata1_q;
    end

    // Tag stages and per-master read-data registers. A reset drops every pending response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_q    <= '0;
            rvalid_q <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            tag_q    <= tag_d;
            rvalid_q <= rvalid_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Without the output register, the RAM word passes straight through on the hit cycle.
    assign rsp_valid = (REG_RDATA != 0) ? rvalid_q : hit;
    assign rsp_data0 = (REG_RDATA != 0) ? rdata0_q : (hit[0] ? ram_readdata : rdata0_q);
    assign rsp_data1 = (REG_RDATA != 0) ? rdata1_q : (hit[1] ? ram_readdata : rdata1_q);

endmodule

// File: rtl/onchip_ram_port_arbiter.sv
// Round-robin arbiter that shares one on-chip RAM port between two Avalon-MM
// masters. It accepts at most one command per cycle. A command is accepted in the
// cycle its waitrequest is low; stalled masters hold their command themselves.
// Read responses come back through rd_tag_pipe.
module onchip_ram_port_arbiter
    import onchip_ram_arb_pkg::*;
#(
    parameter  int ADDR_W     = ADDR_W_DEF,
    parameter  int DATA_W     = DATA_W_DEF,
    parameter  int RAM_RD_LAT = 1,
    parameter  int REG_RDATA  = 0,
    localparam int BE_W       = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              freeze,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    input  logic [DATA_W-1:0] ram_readdata
);

    logic       req0, req1;
    logic       gnt_valid, gnt_id;
    logic       last_grant_q, last_grant_d;
    logic       sel_read, sel_write;
    logic       push_valid;
    logic [1:0] rsp_valid;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Pick a winner: a lone requester wins; under contention the master that did not win last time wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        if (!freeze) begin
            if (req0 && req1) begin
                gnt_valid = 1'b1;
                gnt_id    = ~last_grant_q;
            end else if (req0) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b0;
            end else if (req1) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b1;
            end
        end
    end

    // Round-robin pointer moves only when a command is actually granted.
    always_comb begin
        last_grant_d = gnt_valid ? gnt_id : last_grant_q;
    end

    // Reset to 1 so m0 wins the first contention.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    // Steer the granted command to the RAM. Write wins over read when a master asserts both.
    // Outputs are gated by reset_n, so nothing is accepted while reset is low.
    always_comb begin
        sel_write      = gnt_id ? m1_write : m0_write;
        sel_read       = gnt_id ? m1_read  : m0_read;
        ram_address    = gnt_id ? m1_address    : m0_address;
        ram_byteenable = gnt_id ? m1_byteenable : m0_byteenable;
        ram_writedata  = gnt_id ? m1_writedata  : m0_writedata;
        ram_chipselect = gnt_valid & reset_n;
        ram_write      = gnt_valid & reset_n & sel_write;
        push_valid     = gnt_valid & sel_read & ~sel_write;
        m0_waitrequest = ~reset_n | (gnt_valid ? gnt_id  : req0);
        m1_waitrequest = ~reset_n | (gnt_valid ? ~gnt_id : req1);
    end

    rd_tag_pipe #(
        .DATA_W     (DATA_W),
        .RAM_RD_LAT (RAM_RD_LAT),
        .REG_RDATA  (REG_RDATA)
    ) u_rd_tag_pipe (
        .clk          (clk),
        .reset_n      (reset_n),
        .push_valid   (push_valid),
        .push_id      (gnt_id),
        .ram_readdata (ram_readdata),
        .rsp_valid    (rsp_valid),
        .rsp_data0    (m0_readdata),
        .rsp_data1    (m1_readdata)
    );

    assign m0_readdatavalid = rsp_valid[0];
    assign m1_readdatavalid = rsp_valid[1];

endmodule

// File: tb/tb_onchip_ram_port_arbiter.sv
// Directed bench for onchip_ram_port_arbiter. It builds two instances: one
// with REG_RDATA = 0 (main) and one with REG_RDATA = 1 (r_ prefix). Each instance
// drives its own behavioural 256x32 RAM model, which has a registered address
// and unregistered q.
module tb_onchip_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n, freeze;
    logic [7:0]  m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;

    logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic [31:0] m0_readdata, m1_readdata;
    logic [7:0]  ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect, ram_write;
    logic [31:0] ram_writedata, ram_readdata;

    logic        r_m0_waitrequest, r_m1_waitrequest, r_m0_readdatavalid, r_m1_readdatavalid;
    logic [31:0] r_m0_readdata, r_m1_readdata;
    logic [7:0]  r_ram_address;
    logic [3:0]  r_ram_byteenable;
    logic        r_ram_chipselect, r_ram_write;
    logic [31:0] r_ram_writedata, r_ram_readdata;

    logic [31:0] mem_a [256];
    logic [31:0] mem_r [256];
    logic [7:0]  raddr_a, raddr_r;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    onchip_ram_port_arbiter #(.REG_RDATA(0)) dut (
        .clk(clk), .reset_n(reset_n), .freeze(freeze),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_chipselect(ram_chipselect), .ram_write(ram_write),
        .ram_writedata(ram_writedata), .ram_readdata(ram_readdata)
    );

    onchip_ram_port_arbiter #(.REG_RDATA(1)) dut_r (
        .clk(clk), .reset_n(reset_n), .freeze(freeze),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(r_m0_waitrequest),
        .m0_readdata(r_m0_readdata), .m0_readdatavalid(r_m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(r_m1_waitrequest),
        .m1_readdata(r_m1_readdata), .m1_readdatavalid(r_m1_readdatavalid),
        .ram_address(r_ram_address), .ram_byteenable(r_ram_byteenable),
        .ram_chipselect(r_ram_chipselect), .ram_write(r_ram_write),
        .ram_writedata(r_ram_writedata), .ram_readdata(r_ram_readdata)
    );

    // RAM model for the main instance: byte-enabled write, registered address.
    always @(posedge clk) begin
        if (ram_chipselect) begin
            raddr_a <= ram_address;
            if (ram_write)
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b]) mem_a[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
        end
    end
    assign ram_readdata = mem_a[raddr_a];

    // RAM model for the registered-output instance.
    always @(posedge clk) begin
        if (r_ram_chipselect) begin
            raddr_r <= r_ram_address;
            if (r_ram_write)
                for (int b = 0; b < 4; b++)
                    if (r_ram_byteenable[b]) mem_r[r_ram_address][8*b +: 8] <= r_ram_writedata[8*b +: 8];
        end
    end
    assign r_ram_readdata = mem_r[raddr_r];

    task automatic idle_all();
        m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = 4'hF; m0_writedata = '0;
        m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = 4'hF; m1_writedata = '0;
    endtask

    // Move inputs just after the active edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 0; freeze = 0; idle_all();
        m0_read = 1; m1_write = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_cnt++; if (m0_waitrequest !== 1'b1) $display("FAIL rst_m0_wait got %b exp 1", m0_waitrequest); else pass_cnt++;
        chk_cnt++; if (m1_waitrequest !== 1'b1) $display("FAIL rst_m1_wait got %b exp 1", m1_waitrequest); else pass_cnt++;
        chk_cnt++; if (ram_chipselect !== 1'b0) $display("FAIL rst_cs got %b exp 0", ram_chipselect); else pass_cnt++;
        chk_cnt++; if ({m1_readdatavalid, m0_readdatavalid} !== 2'b00) $display("FAIL rst_rdv got %b exp 00", {m1_readdatavalid, m0_readdatavalid}); else pass_cnt++;
        chk_cnt++; if (m0_readdata !== 32'h0) $display("FAIL rst_rdata got %h exp 0", m0_readdata); else pass_cnt++;
        cyc(); idle_all(); reset_n = 1;
        @(negedge clk);
        chk_cnt++; if ({m1_waitrequest, m0_waitrequest} !== 2'b00) $display("FAIL idle_wait got %b exp 00", {m1_waitrequest, m0_waitrequest}); else pass_cnt++;
    endtask

    task automatic test_single_write_read();
        cyc(); m0_write = 1; m0_address = 8'h10; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
        @(negedge clk);
        chk_cnt++; if (m0_waitrequest !== 1'b0) $display("FAIL wr_m0_wait got %b exp 0", m0_waitrequest); else pass_cnt++;
        chk_cnt++; if (m1_waitrequest !== 1'b1) $display("FAIL wr_m1_wait got %b exp 1", m1_waitrequest); else pass_cnt++;
        chk_cnt++; if ({ram_chipselect, ram_write} !== 2'b11) $display("FAIL wr_cs_we got %b exp 11", {ram_chipselect, ram_write}); else pass_cnt++;
        chk_cnt++; if (ram_address !== 8'h10) $display("FAIL wr_addr got %h exp 10", ram_address); else pass_cnt++;
        cyc(); m0_write = 0; m0_read = 1;
        @(negedge clk);
        chk_cnt++; if ({m0_waitrequest, ram_chipselect, ram_write} !== 3'b010) $display("FAIL rd_accept got %b exp 010", {m0_waitrequest, ram_chipselect, ram_write}); else pass_cnt++;
        chk_cnt++; if (m0_readdatavalid !== 1'b0) $display("FAIL rd_early_rdv got %b exp 0", m0_readdatavalid); else pass_cnt++;
        cyc(); idle_all();
        @(negedge clk);
        chk_cnt++; if ({m1_readdatavalid, m0_readdatavalid} !== 2'b01) $display("FAIL rd_rdv got %b exp 01", {m1_readdatavalid, m0_readdatavalid}); else pass_cnt++;
        chk_cnt++; if (m0_readdata !== 32'hDEADBEEF) $display("FAIL rd_data got %h exp deadbeef", m0_readdata); else pass_cnt++;
        chk_cnt++; if (r_m0_readdatavalid !== 1'b0) $display("FAIL reg_early_rdv got %b exp 0", r_m0_readdatavalid); else pass_cnt++;
        cyc();
        @(negedge clk);
        chk_cnt++; if (m0_readdatavalid !== 1'b0) $display("FAIL rd_pulse_len got %b exp 0", m0_readdatavalid); else pass_cnt++;
        chk_cnt++; if (m0_readdata !== 32'hDEADBEEF) $display("FAIL rd_hold got %h exp deadbeef", m0_readdata); else pass_cnt++;
        chk_cnt++; if ({r_m1_readdatavalid, r_m0_readdatavalid} !== 2'b01) $display("FAIL reg_rdv got %b exp 01", {r_m1_readdatavalid, r_m0_readdatavalid}); else pass_cnt++;
        chk_cnt++; if (r_m0_readdata !== 32'hDEADBEEF) $display("FAIL reg_data got %h exp deadbeef", r_m0_readdata); else pass_cnt++;
        cyc();
        @(negedge clk);
        chk_cnt++; if (r_m0_readdatavalid !== 1'b0) $display("FAIL reg_pulse_len got %b exp 0", r_m0_readdatavalid); else pass_cnt++;
    endtask

    task automatic test_contention();
        // Preload 0x20..0x25 through m1, which leaves last_grant = m1.
        for (int i = 0; i < 6; i++) begin
            cyc(); m1_write = 1; m1_address = 8'(32'h20 + i); m1_writedata = 32'hA500_0000 | (32'h20 + i);
            @(negedge clk);
            chk_cnt++; if (m1_waitrequest !== 1'b0) $display("FAIL pre_wr%0d_wait got %b exp 0", i, m1_waitrequest); else pass_cnt++;
        end
        for (int c = 0; c < 6; c++) begin
            cyc(); m1_write = 0;
            m0_read = 1; m0_address = 8'(32'h20 + 2 * ((c + 1) / 2));
            m1_read = 1; m1_address = 8'(32'h21 + 2 * (c / 2));
            @(negedge clk);
            chk_cnt++; if (ram_address !== 8'(32'h20 + c)) $display("FAIL cont%0d_addr got %h exp %h", c, ram_address, 8'(32'h20 + c)); else pass_cnt++;
            chk_cnt++; if ({m1_waitrequest, m0_waitrequest} !== ((c % 2) ? 2'b01 : 2'b10)) $display("FAIL cont%0d_grant got %b exp %b", c, {m1_waitrequest, m0_waitrequest}, ((c % 2) ? 2'b01 : 2'b10)); else pass_cnt++;
            if (c == 0) begin
                chk_cnt++; if ({m1_readdatavalid, m0_readdatavalid} !== 2'b00) $display("FAIL cont0_rdv got %b exp 00", {m1_readdatavalid, m0_readdatavalid}); else pass_cnt++;
            end else if (((c - 1) % 2) == 0) begin
                chk_cnt++; if ({m1_readdatavalid, m0_readdatavalid} !== 2'b01) $display("FAIL cont%0d_rdv got %b exp 01", c, {m1_readdatavalid, m0_readdatavalid}); else pass_cnt++;
                chk_cnt++; if (m0_readdata !== (32'hA500_0000 | (32'h20 + c - 1))) $display("FAIL cont%0d_data got %h exp %h", c, m0_readdata, 32'hA500_0000 | (32'h20 + c - 1)); else pass_cnt++;
            end else begin
                chk_cnt++; if ({m1_readdatavalid, m0_readdatavalid} !== 2'b10) $display("FAIL cont%0d_rdv got %b exp 10", c, {m1_readdatavalid, m0_readdatavalid}); else pass_cnt++;
                chk_cnt++; if (m1_readdata !== (32'hA500_0000 | (32'h20 + c - 1))) $display("FAIL cont%0d_data got %h exp %h", c, m1_readdata, 32'hA500_0000 | (32'h20 + c - 1)); else pass_cnt++;
            end
        end
        cyc(); idle_all();
        @(negedge clk);
        chk_cnt++; if ({m1_readdatavalid, m0_readdatavalid} !== 2'b10) $display("FAIL cont_last_rdv got %b exp 10", {m1_readdatavalid, m0_readdatavalid}); else pass_cnt++;
        chk_cnt++; if (m1_readdata !== 32'hA500_0025) $display("FAIL cont_last_data got %h exp a5000025", m1_readdata); else pass_cnt++;
        chk_cnt++; if (m0_readdata !== 32'hA500_0024) $display("FAIL cont_m0_hold got %h exp a5000024", m0_readdata); else pass_cnt++;
    endtask

    task automatic test_byte_enables();
        cyc(); m0_write = 1; m0_address = 8'h30; m0_writedata = 32'hFFFF_FFFF; m0_byteenable = 4'hF;
        cyc(); m0_writedata = 32'h0000_0000; m0_byteenable = 4'h5;
        @(negedge clk);
        chk_cnt++; if (ram_byteenable !== 4'h5) $display("FAIL be_mux got %h exp 5", ram_byteenable); else pass_cnt++;
        cyc(); m0_write = 0; m0_read = 1; m0_byteenable = 4'hF;
        @(negedge clk);
        chk_cnt++; if (m0_waitrequest !== 1'b0) $display("FAIL be_rd_wait got %b exp 0", m0_waitrequest); else pass_cnt++;
        cyc(); idle_all();
        @(negedge clk);
        chk_cnt++; if (m0_readdatavalid !== 1'b1) $display("FAIL be_rdv got %b exp 1", m0_readdatavalid); else pass_cnt++;
        chk_cnt++; if (m0_readdata !== 32'hFF00_FF00) $display("FAIL be_data got %h exp ff00ff00", m0_readdata); else pass_cnt++;
    endtask

    task automatic test_freeze();
        cyc(); m1_read = 1; m1_address = 8'h21;
        @(negedge clk);
        chk_cnt++; if (m1_waitrequest !== 1'b0) $display("FAIL frz_m1_accept got %b exp 0", m1_waitrequest); else pass_cnt++;
        cyc(); m1_read = 0; freeze = 1; m0_read = 1; m0_address = 8'h20;
        @(negedge clk);
        chk_cnt++; if (m1_readdatavalid !== 1'b1) $display("FAIL frz_inflight_rdv got %b exp 1", m1_readdatavalid); else pass_cnt++;
        chk_cnt++; if (m1_readdata !== 32'hA500_0021) $display("FAIL frz_inflight_data got %h exp a5000021", m1_readdata); else pass_cnt++;
        chk_cnt++; if ({m0_waitrequest, ram_chipselect} !== 2'b10) $display("FAIL frz_stall got %b exp 10", {m0_waitrequest, ram_chipselect}); else pass_cnt++;
        cyc();
        @(negedge clk);
        chk_cnt++; if ({m0_waitrequest, ram_chipselect, m1_readdatavalid} !== 3'b100) $display("FAIL frz_stall2 got %b exp 100", {m0_waitrequest, ram_chipselect, m1_readdatavalid}); else pass_cnt++;
        // Contention right as freeze drops: m1 won last, so m0 must win now.
        cyc(); freeze = 0; m1_read = 1; m1_address = 8'h23;
        @(negedge clk);
        chk_cnt++; if ({m1_waitrequest, m0_waitrequest} !== 2'b10) $display("FAIL frz_release_grant got %b exp 10", {m1_waitrequest, m0_waitrequest}); else pass_cnt++;
        chk_cnt++; if (ram_address !== 8'h20) $display("FAIL frz_release_addr got %h exp 20", ram_address); else pass_cnt++;
        cyc(); m0_read = 0;
        @(negedge clk);
        chk_cnt++; if ({m1_waitrequest, ram_address} !== {1'b0, 8'h23}) $display("FAIL frz_m1_next got %b/%h exp 0/23", m1_waitrequest, ram_address); else pass_cnt++;
        chk_cnt++; if ({m0_readdatavalid, m0_readdata} !== {1'b1, 32'hA500_0020}) $display("FAIL frz_m0_rsp got %b/%h exp 1/a5000020", m0_readdatavalid, m0_readdata); else pass_cnt++;
        cyc(); idle_all();
        @(negedge clk);
        chk_cnt++; if ({m1_readdatavalid, m1_readdata} !== {1'b1, 32'hA500_0023}) $display("FAIL frz_m1_rsp got %b/%h exp 1/a5000023", m1_readdatavalid, m1_readdata); else pass_cnt++;
    endtask

    task automatic test_reset_mid_read();
        cyc(); m0_read = 1; m0_address = 8'h20;
        @(negedge clk);
        chk_cnt++; if (m0_waitrequest !== 1'b0) $display("FAIL rmr_accept got %b exp 0", m0_waitrequest); else pass_cnt++;
        #1; reset_n = 0; m1_read = 1; m1_address = 8'h21;
        @(negedge clk);
        chk_cnt++; if ({m1_readdatavalid, m0_readdatavalid} !== 2'b00) $display("FAIL rmr_rdv got %b exp 00", {m1_readdatavalid, m0_readdatavalid}); else pass_cnt++;
        chk_cnt++; if (m0_readdata !== 32'h0) $display("FAIL rmr_rdata got %h exp 0", m0_readdata); else pass_cnt++;
        chk_cnt++; if ({m1_waitrequest, m0_waitrequest, ram_chipselect} !== 3'b110) $display("FAIL rmr_wait got %b exp 110", {m1_waitrequest, m0_waitrequest, ram_chipselect}); else pass_cnt++;
        cyc(); reset_n = 1;
        @(negedge clk);
        chk_cnt++; if ({m1_waitrequest, m0_waitrequest} !== 2'b10) $display("FAIL rmr_first_grant got %b exp 10", {m1_waitrequest, m0_waitrequest}); else pass_cnt++;
        chk_cnt++; if ({m1_readdatavalid, m0_readdatavalid, r_m1_readdatavalid, r_m0_readdatavalid} !== 4'b0000) $display("FAIL rmr_no_stale got %b exp 0000", {m1_readdatavalid, m0_readdatavalid, r_m1_readdatavalid, r_m0_readdatavalid}); else pass_cnt++;
        cyc(); m0_read = 0;
        @(negedge clk);
        chk_cnt++; if ({m0_readdatavalid, m0_readdata} !== {1'b1, 32'hA500_0020}) $display("FAIL rmr_new_rsp got %b/%h exp 1/a5000020", m0_readdatavalid, m0_readdata); else pass_cnt++;
        cyc(); idle_all();
        @(negedge clk);
        chk_cnt++; if ({m1_readdatavalid, m1_readdata} !== {1'b1, 32'hA500_0021}) $display("FAIL rmr_m1_rsp got %b/%h exp 1/a5000021", m1_readdatavalid, m1_readdata); else pass_cnt++;
        repeat (3) cyc();
    endtask

    initial begin
        test_reset();
        test_single_write_read();
        test_contention();
        test_byte_enables();
        test_freeze();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
